// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES mode controller and its neighbours.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  localparam bit AES_MODE_ECB = 1'b0;
  localparam bit AES_MODE_CBC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// CBC/ECB chaining controller in front of the iterative AES core: one block in
// flight at a time, start/done to the core, results on a valid/ready port.
module aes_cbc_ctrl
  import aes_pkg::*;
#(
  parameter bit MODE_CBC = AES_MODE_CBC
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_fInit,
  input  logic                 i_fDec,
  input  logic [AES_BLK_W-1:0] i_Key,
  input  logic [AES_BLK_W-1:0] i_IV,
  input  logic                 i_fInVld,
  output logic                 o_fInRdy,
  input  logic [AES_BLK_W-1:0] i_InText,
  output logic                 o_fOutVld,
  input  logic                 i_fOutRdy,
  output logic [AES_BLK_W-1:0] o_OutText,
  output logic                 o_fCoreStart,
  output logic                 o_fCoreDec,
  output logic [AES_BLK_W-1:0] o_CoreKey,
  output logic [AES_BLK_W-1:0] o_CoreText,
  input  logic                 i_fCoreDone,
  input  logic [AES_BLK_W-1:0] i_CoreText,
  output logic                 o_fBusy,
  output logic [2:0]           o_State
);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid never drops without ready, data holds meanwhile.

  localparam bit CHAIN_EN = (MODE_CBC != AES_MODE_ECB);

  aes_state_e state_q, state_d;

  logic [AES_BLK_W-1:0] key_q, chain_q, pend_q, ctext_q, out_q;
  logic                 dec_q;

  logic init_ok, accept, done_cap;
  logic in_rdy, core_start, out_vld, busy;

  assign init_ok  = i_fInit && ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign accept   = (state_q == ST_READY) && i_fInVld && !i_fInit;
  assign done_cap = (state_q == ST_WAIT) && i_fCoreDone;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_rdy     = 1'b0;
    core_start = 1'b0;
    out_vld    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fInit) state_d = ST_READY;
      end
      ST_READY: begin
        // Init wins over a block offered in the same cycle.
        in_rdy = !i_fInit;
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (i_fCoreDone) state_d = ST_OUT;
      end
      ST_OUT: begin
        busy    = 1'b1;
        out_vld = 1'b1;
        if (i_fOutRdy) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      key_q   <= '0;
      dec_q   <= 1'b0;
      chain_q <= '0;
      pend_q  <= '0;
      ctext_q <= '0;
      out_q   <= '0;
    end else begin
      if (init_ok) begin
        key_q   <= i_Key;
        dec_q   <= i_fDec;
        chain_q <= CHAIN_EN ? i_IV : '0;
      end
      if (accept) begin
        if (CHAIN_EN && !dec_q) ctext_q <= i_InText ^ chain_q;
        else                    ctext_q <= i_InText;
        // Decrypt needs this ciphertext as the chain value for the next block.
        if (CHAIN_EN && dec_q) pend_q <= i_InText;
      end
      if (done_cap) begin
        if (CHAIN_EN && !dec_q) begin
          out_q   <= i_CoreText;
          chain_q <= i_CoreText;
        end else if (CHAIN_EN) begin
          out_q   <= i_CoreText ^ chain_q;
          chain_q <= pend_q;
        end else begin
          out_q   <= i_CoreText;
        end
      end
    end
  end

  assign o_fInRdy     = in_rdy;
  assign o_fOutVld    = out_vld;
  assign o_OutText    = out_q;
  assign o_fCoreStart = core_start;
  assign o_fCoreDec   = dec_q;
  assign o_CoreKey    = key_q;
  assign o_CoreText   = ctext_q;
  assign o_fBusy      = busy;
  assign o_State      = state_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Bench for aes_cbc_ctrl: a CBC and an ECB instance run in lockstep against a
// stand-in AES core and a block-level chaining model.
module tb_aes_cbc_ctrl;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         init = 1'b0, dec = 1'b0, in_vld = 1'b0, out_rdy = 1'b0;
  logic [127:0] key = '0, iv = '0, in_text = '0;

  logic         in_rdy [2], out_vld [2], start [2], core_dec [2], busy [2], core_done [2];
  logic [127:0] out_text [2], core_key [2], core_text_o [2], core_res [2];
  logic [2:0]   st [2];

  aes_cbc_ctrl #(.MODE_CBC(1'b1)) u_cbc (
    .i_Clk(clk), .i_Rst(rst_n), .i_fInit(init), .i_fDec(dec), .i_Key(key), .i_IV(iv),
    .i_fInVld(in_vld), .o_fInRdy(in_rdy[0]), .i_InText(in_text),
    .o_fOutVld(out_vld[0]), .i_fOutRdy(out_rdy), .o_OutText(out_text[0]),
    .o_fCoreStart(start[0]), .o_fCoreDec(core_dec[0]), .o_CoreKey(core_key[0]),
    .o_CoreText(core_text_o[0]), .i_fCoreDone(core_done[0]), .i_CoreText(core_res[0]),
    .o_fBusy(busy[0]), .o_State(st[0])
  );

  aes_cbc_ctrl #(.MODE_CBC(1'b0)) u_ecb (
    .i_Clk(clk), .i_Rst(rst_n), .i_fInit(init), .i_fDec(dec), .i_Key(key), .i_IV(iv),
    .i_fInVld(in_vld), .o_fInRdy(in_rdy[1]), .i_InText(in_text),
    .o_fOutVld(out_vld[1]), .i_fOutRdy(out_rdy), .o_OutText(out_text[1]),
    .o_fCoreStart(start[1]), .o_fCoreDec(core_dec[1]), .o_CoreKey(core_key[1]),
    .o_CoreText(core_text_o[1]), .i_fCoreDone(core_done[1]), .i_CoreText(core_res[1]),
    .o_fBusy(busy[1]), .o_State(st[1])
  );

  // ---------------- reference vectors ----------------
  logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Stand-in block cipher: exact AES on the known vectors, an invertible
  // rotate/XOR permutation everywhere else.
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] x);
    if (k == K1 && x == (P1 ^ IV1)) return C1;
    if (k == K1 && x == (P2 ^ C1))  return C2;
    if (k == K2 && x == PT2)        return CT2;
    return {x[114:0] ^ k[114:0], x[127:115] ^ k[127:115]};
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] y);
    if (k == K1 && y == C1)  return P1 ^ IV1;
    if (k == K1 && y == C2)  return P2 ^ C1;
    if (k == K2 && y == CT2) return PT2;
    return {y[12:0], y[127:13]} ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycles from the accept edge to the first valid output cycle.
  function automatic int lat_of(input bit d);
    return d ? 22 : 12;
  endfunction

  // ---------------- stand-in core: done 11 (enc) / 21 (dec) cycles after start ----------------
  for (genvar g = 0; g < 2; g++) begin : g_core
    initial begin
      logic [127:0] r;
      int           lat;
      bit           abort;
      core_done[g] = 1'b0;
      core_res[g]  = '0;
      forever begin
        @(posedge clk);
        if (rst_n && start[g]) begin
          lat   = core_dec[g] ? 20 : 10;
          r     = core_dec[g] ? aes_dec(core_key[g], core_text_o[g]) : aes_enc(core_key[g], core_text_o[g]);
          abort = 1'b0;
          for (int i = 0; i < lat; i++) begin
            @(posedge clk);
            if (!rst_n) abort = 1'b1;
          end
          if (!abort) begin
            #1;
            core_done[g] = 1'b1;
            core_res[g]  = r;
            @(posedge clk);
            #1;
            core_done[g] = 1'b0;
            core_res[g]  = '0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int m, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  // Block-level model: per instance, whether a key is loaded, whether a block
  // is in flight, the chain value, and the expected results.
  bit           m_init [2], m_busy [2], m_dec [2];
  logic [127:0] m_key [2], m_chain [2], m_ctext [2];
  int           m_acc [2];
  int           cyc = 0;
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];

  function automatic logic [127:0] q_front(input int m);
    if (m == 0) return (exp_q0.size() > 0) ? exp_q0[0] : 128'hx;
    return (exp_q1.size() > 0) ? exp_q1[0] : 128'hx;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_init[m] = 0; m_busy[m] = 0; m_dec[m] = 0;
      m_key[m] = '0; m_chain[m] = '0; m_ctext[m] = '0; m_acc[m] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int m = 0; m < 2; m++) begin
          m_init[m] = 0; m_busy[m] = 0; m_dec[m] = 0;
          m_key[m] = '0; m_chain[m] = '0; m_ctext[m] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        for (int m = 0; m < 2; m++) begin
          bit           hs;
          logic [127:0] y;
          hs = m_busy[m] && (cyc - m_acc[m] >= lat_of(m_dec[m])) && out_rdy;
          if (!m_busy[m] && init) begin
            m_key[m]   = key;
            m_dec[m]   = dec;
            m_chain[m] = iv;
            m_init[m]  = 1;
          end else if (!m_busy[m] && m_init[m] && in_vld) begin
            if (m == 0 && !m_dec[m]) begin
              m_ctext[m] = in_text ^ m_chain[m];
              y          = aes_enc(m_key[m], m_ctext[m]);
              m_chain[m] = y;
            end else if (m == 0) begin
              m_ctext[m] = in_text;
              y          = aes_dec(m_key[m], in_text) ^ m_chain[m];
              m_chain[m] = in_text;
            end else begin
              m_ctext[m] = in_text;
              y          = m_dec[m] ? aes_dec(m_key[m], in_text) : aes_enc(m_key[m], in_text);
            end
            if (m == 0) exp_q0.push_back(y);
            else        exp_q1.push_back(y);
            m_busy[m] = 1;
            m_acc[m]  = cyc + 1;
          end
          if (hs) begin
            m_busy[m] = 0;
            if (m == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
          end
        end
        cyc++;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int m = 0; m < 2; m++) begin
          bit ev;
          ev = m_busy[m] && (cyc - m_acc[m] >= lat_of(m_dec[m]));
          chk("in_rdy",    m, in_rdy[m],      m_init[m] && !m_busy[m] && !init);
          chk("busy",      m, busy[m],        m_busy[m]);
          chk("core_start",m, start[m],       m_busy[m] && (cyc == m_acc[m]));
          chk("out_vld",   m, out_vld[m],     ev);
          chk("core_key",  m, core_key[m],    m_key[m]);
          chk("core_dec",  m, core_dec[m],    m_dec[m]);
          chk("core_text", m, core_text_o[m], m_ctext[m]);
          if (ev && out_vld[m]) chk("out_text", m, out_text[m], q_front(m));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_init(input logic [127:0] k, input logic [127:0] v, input bit d);
    @(posedge clk); #1;
    init = 1'b1; key = k; iv = v; dec = d;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic send(input logic [127:0] x);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_vld = 1'b1; in_text = x;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      if (in_rdy[0]) ok = 1;
    end
    #1;
    in_vld = 1'b0;
    chk("send_accept", 0, ok, 1'b1);
  endtask

  task automatic recv(input int stall, output logic [127:0] y0, output logic [127:0] y1);
    bit ok;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (out_vld[0]) ok = 1;
    end
    chk("recv_valid", 0, ok, 1'b1);
    y0 = out_text[0];
    y1 = out_text[1];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_text", 0, out_text[0], y0);
      chk("hold_rdy",  0, in_rdy[0], 1'b0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic reset_checks(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_in_rdy"},  m, in_rdy[m], 1'b0);
      chk({nm, "_out_vld"}, m, out_vld[m], 1'b0);
      chk({nm, "_start"},   m, start[m], 1'b0);
      chk({nm, "_dec"},     m, core_dec[m], 1'b0);
      chk({nm, "_key"},     m, core_key[m], '0);
      chk({nm, "_ctext"},   m, core_text_o[m], '0);
      chk({nm, "_otext"},   m, out_text[m], '0);
      chk({nm, "_busy"},    m, busy[m], 1'b0);
      chk({nm, "_state"},   m, st[m], ST_IDLE);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] y0, y1, held;
    bit           ok;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // CBC encrypt, SP800-38A
    do_init(K1, IV1, 1'b0);
    send(P1); recv(0, y0, y1); chk("cbc_enc_p1", 0, y0, C1);
    send(P2); recv(1, y0, y1); chk("cbc_enc_p2", 0, y0, C2);

    // CBC decrypt back
    do_init(K1, IV1, 1'b1);
    send(C1); recv(0, y0, y1); chk("cbc_dec_c1", 0, y0, P1);
    send(C2); recv(2, y0, y1); chk("cbc_dec_c2", 0, y0, P2);

    // ECB, FIPS-197 vector
    do_init(K2, rnd128(), 1'b0);
    send(PT2); recv(0, y0, y1); chk("ecb_enc", 1, y1, CT2);
    do_init(K2, rnd128(), 1'b1);
    send(CT2); recv(0, y0, y1); chk("ecb_dec", 1, y1, PT2);

    // Backpressure: 20 stalled cycles, next block right after the handshake
    do_init(K1, IV1, 1'b0);
    send(P1);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (out_vld[0]) ok = 1;
    end
    chk("bp_valid", 0, ok, 1'b1);
    held = out_text[0];
    chk("bp_text", 0, held, C1);
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      chk("bp_hold_text", 0, out_text[0], held);
      chk("bp_hold_vld",  0, out_vld[0], 1'b1);
      chk("bp_hold_rdy",  0, in_rdy[0], 1'b0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1; in_vld = 1'b1; in_text = P2;
    @(negedge clk);
    chk("bp_rdy_at_hs", 0, in_rdy[0], 1'b0);
    @(posedge clk); #1;
    out_rdy = 1'b0;
    @(negedge clk);
    chk("bp_rdy_after", 0, in_rdy[0], 1'b1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 0, busy[0], 1'b1);
    recv(0, y0, y1); chk("bp_chain_p2", 0, y0, C2);

    // Init together with a block in READY: block refused, IV reloaded
    @(posedge clk); #1;
    init = 1'b1; key = K1; iv = IV1; dec = 1'b0; in_vld = 1'b1; in_text = rnd128();
    @(negedge clk);
    chk("init_vld_rdy", 0, in_rdy[0], 1'b0);
    @(posedge clk); #1;
    init = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    chk("init_vld_busy", 0, busy[0], 1'b0);
    send(P1); recv(0, y0, y1); chk("reinit_p1", 0, y0, C1);

    // Randomised sessions
    for (int r = 0; r < 6; r++) begin
      do_init(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        send(rnd128());
        recv($urandom_range(0, 4), y0, y1);
      end
    end

    // Reset while the core is working
    do_init(K1, IV1, 1'b1);
    send(C1);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_state", 0, st[0], ST_IDLE);
    chk("post_rst_vld",   0, out_vld[0], 1'b0);
    chk("post_rst_state", 1, st[1], ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
